// File: rtl/sonic_ring_pkg.sv
// rtl/sonic_ring_pkg.sv - shared ring-buffer widths, pointer type, reader states and helpers
package sonic_ring_pkg;

  localparam int RING_AW = 13;
  localparam int RING_PW = 14;
  localparam int RING_DW = 128;

  typedef logic [RING_PW-1:0] ring_ptr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rdr_state_e;

  // Occupancy between producer and consumer pointers; the wrap bit makes this modular.
  function automatic ring_ptr_t ring_avail(input ring_ptr_t wptr, input ring_ptr_t rptr);
    return wptr - rptr;
  endfunction

endpackage

// File: rtl/sonic_rx_ring_reader_if.sv
// rtl/sonic_rx_ring_reader_if.sv - ring read port, output stream and status of the RX ring reader
interface sonic_rx_ring_reader_if
  import sonic_ring_pkg::*;
#(
  parameter int ADDR_WIDTH = RING_AW,
  parameter int DATA_WIDTH = RING_DW
);

  logic                  enable;
  logic [ADDR_WIDTH:0]   rx_ring_wptr;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic                  dma_rdreq;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH:0]   rx_ring_rptr;
  logic                  busy;
  logic                  ptr_err;

  modport master (
    input  enable, rx_ring_wptr, data_in, out_ready,
    output rd_address, dma_rdreq, out_data, out_valid, rx_ring_rptr, busy, ptr_err
  );

  modport slave (
    output enable, rx_ring_wptr, data_in, out_ready,
    input  rd_address, dma_rdreq, out_data, out_valid, rx_ring_rptr, busy, ptr_err
  );

endinterface

// File: rtl/sonic_skid_fifo.sv
// rtl/sonic_skid_fifo.sv - synchronous FIFO with occupancy count and same-cycle push/pop
module sonic_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_idx <= (wr_idx == AW'(DEPTH - 1)) ? '0 : wr_idx + 1'b1;
      end
      if (do_pop) begin
        rd_idx <= (rd_idx == AW'(DEPTH - 1)) ? '0 : rd_idx + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sonic_rx_ring_reader.sv
// rtl/sonic_rx_ring_reader.sv - reads RX ring words, absorbs read latency, publishes commit pointer
module sonic_rx_ring_reader
  import sonic_ring_pkg::*;
#(
  parameter int ADDR_WIDTH = RING_AW,
  parameter int DATA_WIDTH = RING_DW,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                    rd_clock,
  input logic                    reset,
  sonic_rx_ring_reader_if.master ring
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = 8;
  localparam ring_ptr_t AVAIL_MAX = ring_ptr_t'(2 ** ADDR_WIDTH);

  rdr_state_e            state;
  rdr_state_e            state_nxt;
  ring_ptr_t             issue_ptr;
  ring_ptr_t             rptr;
  ring_ptr_t             avail;
  logic                  avail_bad;
  logic [ADDR_WIDTH-1:0] rd_address_q;
  logic                  dma_rdreq_q;
  logic                  ptr_err_q;
  logic [RD_LATENCY:1]   lat_pipe;
  logic                  arrive;
  logic                  pop;
  logic                  issue;
  logic                  credit_ok;
  logic [SW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  sonic_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (rd_clock),
    .reset     (reset),
    .push      (arrive),
    .push_data (ring.data_in),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign arrive    = lat_pipe[RD_LATENCY];
  assign pop       = !fifo_empty && ring.out_ready;
  assign avail     = ring_avail(ring.rx_ring_wptr, issue_ptr);
  assign avail_bad = (avail > AVAIL_MAX);

  // Reads whose data has not yet reached data_in; the word landing this cycle is counted separately.
  always_comb begin
    inflight = SW'(dma_rdreq_q);
    for (int i = 1; i < RD_LATENCY; i++) begin
      inflight = inflight + SW'(lat_pipe[i]);
    end
  end

  // Credit uses the occupancy after this cycle's landing word and pop, so 1 word/clk is sustained.
  assign credit_ok = (SW'(fifo_count) + inflight + SW'(arrive)) < (SW'(FIFO_DEPTH) + SW'(pop));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (ring.enable) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!ring.enable) begin
          state_nxt = DRAIN;
        end else begin
          issue = (avail != '0) && !avail_bad && !ptr_err_q && credit_ok;
        end
      end
      DRAIN: begin
        if (ring.enable) begin
          state_nxt = RUN;
        end else if ((inflight == '0) && !arrive && fifo_empty) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clock) begin
    if (reset) begin
      state        <= IDLE;
      issue_ptr    <= '0;
      rptr         <= '0;
      rd_address_q <= '0;
      dma_rdreq_q  <= 1'b0;
      ptr_err_q    <= 1'b0;
      lat_pipe     <= '0;
    end else begin
      state       <= state_nxt;
      dma_rdreq_q <= issue;
      if (issue) begin
        rd_address_q <= issue_ptr[ADDR_WIDTH-1:0];
        issue_ptr    <= issue_ptr + 1'b1;
      end
      lat_pipe[1] <= dma_rdreq_q;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        lat_pipe[i] <= lat_pipe[i-1];
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (avail_bad) begin
        ptr_err_q <= 1'b1;
      end
    end
  end

  assign ring.rd_address   = rd_address_q;
  assign ring.dma_rdreq    = dma_rdreq_q;
  assign ring.out_data     = fifo_head;
  assign ring.out_valid    = !fifo_empty;
  assign ring.rx_ring_rptr = rptr;
  assign ring.busy         = (state != IDLE);
  assign ring.ptr_err      = ptr_err_q;

endmodule

// File: tb/tb_sonic_rx_ring_reader.sv
// tb/tb_sonic_rx_ring_reader.sv - scoreboard bench for the RX ring reader
module tb_sonic_rx_ring_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sonic_rx_ring_reader_if #(.ADDR_WIDTH(13), .DATA_WIDTH(128)) ring_if ();

  sonic_rx_ring_reader #(
    .ADDR_WIDTH (13),
    .DATA_WIDTH (128),
    .RD_LATENCY (2),
    .FIFO_DEPTH (4)
  ) dut (
    .rd_clock (clk),
    .reset    (reset),
    .ring     (ring_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [127:0] exp_q[$];
  logic [12:0]  addr_log[$];
  logic [13:0]  wptr_model;
  logic [13:0]  model_issue;
  logic [13:0]  model_rptr;
  int           rdreq_cnt;
  int           delivered;
  int           first_rdreq_cyc;
  int           last_rdreq_cyc;
  int           first_valid_cyc;
  logic [12:0]  a_d1 = '0;
  logic [12:0]  a_d2 = '0;

  function automatic logic [127:0] mem_word(input logic [12:0] a);
    logic [31:0] w;
    w = {19'b0, a};
    return {32'hC0DE_0000 | w, w ^ 32'h1234_5678, w * 32'd2654435761, ~w};
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Ring memory read port with a two-cycle latency.
  always @(posedge clk) begin
    a_d1 <= ring_if.rd_address;
    a_d2 <= a_d1;
  end
  assign ring_if.data_in = mem_word(a_d2);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (ring_if.dma_rdreq) begin
        check("rd_address", ring_if.rd_address, model_issue[12:0]);
        if (first_rdreq_cyc < 0) first_rdreq_cyc = cyc;
        last_rdreq_cyc = cyc;
        addr_log.push_back(ring_if.rd_address);
        model_issue++;
        rdreq_cnt++;
      end
      if (ring_if.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (ring_if.out_valid && ring_if.out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("out_data", ring_if.out_data, exp_q.pop_front());
        check("rptr_track", ring_if.rx_ring_rptr, model_rptr);
        model_rptr++;
        delivered++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    addr_log.delete();
    wptr_model      = '0;
    model_issue     = '0;
    model_rptr      = '0;
    rdreq_cnt       = 0;
    delivered       = 0;
    first_rdreq_cyc = -1;
    last_rdreq_cyc  = -1;
    first_valid_cyc = -1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    ring_if.enable       = 1'b0;
    ring_if.out_ready    = 1'b0;
    ring_if.rx_ring_wptr = '0;
    tick(2);
    clear_model();
    reset = 1'b0;
  endtask

  task automatic set_wptr(input logic [13:0] nw);
    for (logic [13:0] p = wptr_model; p != nw; p++) exp_q.push_back(mem_word(p[12:0]));
    wptr_model = nw;
    ring_if.rx_ring_wptr = nw;
  endtask

  task automatic wait_rptr(input string tag, input logic [13:0] target, input int budget);
    int i;
    i = 0;
    while (ring_if.rx_ring_rptr !== target && i < budget) begin
      tick(1);
      i++;
    end
    check(tag, ring_if.rx_ring_rptr, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    logic saw_valid;
    reset = 1'b1;
    ring_if.enable       = 1'b0;
    ring_if.out_ready    = 1'b0;
    ring_if.rx_ring_wptr = '0;
    clear_model();
    tick(3);
    check("rst_out_valid", ring_if.out_valid, 0);
    check("rst_dma_rdreq", ring_if.dma_rdreq, 0);
    check("rst_rd_address", ring_if.rd_address, 0);
    check("rst_rptr", ring_if.rx_ring_rptr, 0);
    check("rst_busy", ring_if.busy, 0);
    check("rst_ptr_err", ring_if.ptr_err, 0);
    check("rst_out_data", ring_if.out_data, 0);
    reset = 1'b0;

    // Basic read of three words
    do_reset();
    ring_if.enable = 1'b1;
    ring_if.out_ready = 1'b1;
    set_wptr(14'd3);
    wait_rptr("basic_rptr", 14'd3, 40);
    check("basic_rdreq_cnt", rdreq_cnt, 3);
    check("basic_consecutive", last_rdreq_cyc - first_rdreq_cyc, 2);
    check("basic_latency", first_valid_cyc - first_rdreq_cyc, 3);
    check("basic_delivered", delivered, 3);
    check("basic_sb_empty", exp_q.size(), 0);

    // Backpressure: credit limits issue to the FIFO depth
    do_reset();
    ring_if.enable = 1'b1;
    set_wptr(14'd10);
    tick(20);
    check("bp_rdreq_cnt", rdreq_cnt, 4);
    check("bp_out_valid", ring_if.out_valid, 1);
    check("bp_rptr_held", ring_if.rx_ring_rptr, 0);
    ring_if.out_ready = 1'b1;
    wait_rptr("bp_rptr", 14'd10, 60);
    check("bp_rdreq_total", rdreq_cnt, 10);
    check("bp_delivered", delivered, 10);
    check("bp_sb_empty", exp_q.size(), 0);

    // Wrap across address 8191
    do_reset();
    ring_if.enable = 1'b1;
    ring_if.out_ready = 1'b1;
    set_wptr(14'd8190);
    wait_rptr("wrap_fill_rptr", 14'd8190, 9000);
    addr_log.delete();
    set_wptr(14'h2002);
    wait_rptr("wrap_rptr", 14'h2002, 40);
    check("wrap_addr_cnt", addr_log.size(), 4);
    check("wrap_addr0", addr_log[0], 13'd8190);
    check("wrap_addr1", addr_log[1], 13'd8191);
    check("wrap_addr2", addr_log[2], 13'd0);
    check("wrap_addr3", addr_log[3], 13'd1);
    check("wrap_ptr_err", ring_if.ptr_err, 0);

    // Drain with two reads in flight
    do_reset();
    ring_if.enable = 1'b1;
    ring_if.out_ready = 1'b1;
    set_wptr(14'd6);
    tick(3);
    ring_if.enable = 1'b0;
    check("drain_busy_held", ring_if.busy, 1);
    i = 0;
    while (ring_if.busy !== 1'b0 && i < 50) begin
      tick(1);
      i++;
    end
    check("drain_busy_fell", ring_if.busy, 0);
    check("drain_delivered", delivered, 2);
    check("drain_fifo_empty", ring_if.out_valid, 0);
    tick(5);
    check("drain_rdreq_cnt", rdreq_cnt, 2);

    // Pointer error is sticky until reset
    do_reset();
    ring_if.enable = 1'b1;
    ring_if.out_ready = 1'b1;
    tick(3);
    check("err_clear_before", ring_if.ptr_err, 0);
    ring_if.rx_ring_wptr = 14'd9000;
    tick(1);
    check("err_set_next", ring_if.ptr_err, 1);
    tick(5);
    check("err_no_rdreq", rdreq_cnt, 0);
    ring_if.rx_ring_wptr = '0;
    tick(3);
    check("err_sticky", ring_if.ptr_err, 1);
    do_reset();
    check("err_reset_clears", ring_if.ptr_err, 0);

    // Reset during a five-word burst
    do_reset();
    ring_if.enable = 1'b1;
    ring_if.out_ready = 1'b1;
    set_wptr(14'd5);
    i = 0;
    while (delivered < 2 && i < 40) begin
      tick(1);
      i++;
    end
    check("mid_started", delivered >= 2, 1);
    reset = 1'b1;
    ring_if.enable = 1'b0;
    tick(1);
    check("mid_out_valid", ring_if.out_valid, 0);
    check("mid_dma_rdreq", ring_if.dma_rdreq, 0);
    check("mid_rptr", ring_if.rx_ring_rptr, 0);
    check("mid_busy", ring_if.busy, 0);
    clear_model();
    wptr_model = 14'd5;
    reset = 1'b0;
    saw_valid = 1'b0;
    repeat (8) begin
      tick(1);
      if (ring_if.out_valid) saw_valid = 1'b1;
    end
    check("mid_late_data_dropped", saw_valid, 0);
    check("mid_no_rdreq", rdreq_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sonic_rx_ring_reader.md
Name: sonic_rx_ring_reader

Overview:
- Consumer side of the RX channel ring buffer. The RX channel writes 128-bit words into its ring and advances rx_ring_wptr; this block reads those words back.
- It issues rd_address/dma_rdreq into the RX channel read port and absorbs the fixed read latency in a small skid FIFO.
- Words are presented on a valid/ready stream, and the commit pointer rx_ring_rptr is published for host-side flow control.
- Sits in the rd_clock domain between sonic_rx_chan_66 and the DMA engine / loopback bench checker.

Parameters:
- ADDR_WIDTH, 13: ring word-address width; pointers are ADDR_WIDTH+1 bits, the MSB being the wrap bit.
- DATA_WIDTH, 128: ring word width.
- RD_LATENCY, 2: cycles from dma_rdreq to valid data_in; legal range 1..4.
- FIFO_DEPTH, 4: skid FIFO entries; power of two, must be >= RD_LATENCY.

Ports:
- rd_clock, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: level; 1 = fetch words, 0 = drain and stop.
- rx_ring_wptr, in, 14: producer pointer from the RX channel, synchronous to rd_clock.
- rd_address, out, 13: ring read address.
- dma_rdreq, out, 1: one-cycle read strobe per word.
- data_in, in, 128: ring read data, valid RD_LATENCY cycles after dma_rdreq.
- out_data, out, 128: FIFO head.
- out_valid, out, 1: out_data valid.
- out_ready, in, 1: downstream accept.
- rx_ring_rptr, out, 14: commit pointer, counting consumed words.
- busy, out, 1: state != IDLE.
- ptr_err, out, 1: sticky pointer-inconsistency flag.

Behaviour:
- Reset is synchronous, active-high, single clock rd_clock. On reset, all of the following are cleared and state = IDLE: rd_address, dma_rdreq, out_valid, out_data, rx_ring_rptr, issue_ptr, busy, ptr_err, the FIFO, and the latency pipe.
- Pointers:
  - issue_ptr and rx_ring_rptr are 14-bit and wrap naturally mod 2^14.
  - avail = (rx_ring_wptr - issue_ptr) mod 2^14.
  - avail == 0 means empty.
  - avail > 2^13 is illegal: set ptr_err (sticky until reset) and stop issuing.
- Credit:
  - inflight counts reads issued whose data has not yet arrived (0..RD_LATENCY).
  - A read may issue only when fifo_count + inflight < FIFO_DEPTH, so data_in can never overflow the FIFO.
- Issue: in RUN, if avail != 0, credit is OK and ptr_err = 0:
  - assert dma_rdreq for that cycle, with rd_address = issue_ptr[12:0];
  - issue_ptr increments.
  - At most one read per cycle, so back-to-back reads sustain 1 word/clk when out_ready = 1.
- Return: a RD_LATENCY-deep shift of the rdreq strobe writes data_in into the FIFO. Write and pop in the same cycle are both honoured.
- Output:
  - out_valid = FIFO non-empty.
  - Handshake on out_valid && out_ready: pop, and rx_ring_rptr increments in the same clock edge.
  - out_data holds stable while out_valid && !out_ready.
- FSM:
  - IDLE -> RUN when enable = 1.
  - RUN -> DRAIN when enable = 0. Issuing stops immediately; in-flight reads still land.
  - DRAIN -> IDLE when inflight == 0 and the FIFO is empty.
  - DRAIN -> RUN if enable reasserts first.
  - ptr_err forces no further issue in any state; the FSM may still drain to IDLE.
- Wrap: address 8191 is followed by 0 and the wrap bit toggles. Pointer 16383 + 1 = 0.
- Latency: rdreq at cycle t gives out_valid at t + RD_LATENCY + 1 when the FIFO was empty.

Decomposition:
- Shared package sonic_ring_pkg:
  - RING_AW = 13, RING_PW = 14, RING_DW = 128;
  - typedef ring_ptr_t (logic [13:0]);
  - typedef rdr_state_e {IDLE, RUN, DRAIN};
  - function ring_avail(wptr, rptr) returning the wrapped difference.
- One sub-module, sonic_skid_fifo: parameterized synchronous FIFO with DEPTH/WIDTH parameters, count output, and simultaneous push/pop support. Reusable by the TX-side ring writer.

Test Plan:
- Basic read: reset, enable = 1, wptr 0 -> 3, out_ready = 1.
  - dma_rdreq on 3 consecutive cycles with addresses 0, 1, 2.
  - Three words out, in order; rptr ends at 3.
  - First out_valid exactly RD_LATENCY + 1 cycles after the first rdreq.
- Backpressure: wptr = 10, out_ready = 0.
  - Exactly FIFO_DEPTH rdreqs issue, then none.
  - Raising out_ready drains all 10 words in order; rptr = 10, with no loss or duplication.
- Wrap: force issue and rptr to 8190 via a reset-then-fill sequence (writer pointer 8190 consumed); wptr = 8194 (0x2002).
  - Addresses observed: 8190, 8191, 0, 1.
  - rptr = 0x2002.
- Drain: deassert enable with 2 reads in flight.
  - No further rdreq is issued.
  - The 2 words are still delivered.
  - busy falls after the FIFO empties.
- Error: wptr = issue_ptr + 9000 mod 2^14.
  - ptr_err = 1 on the next cycle; no rdreq.
  - ptr_err persists until reset, and reset clears it.
- Reset mid-run: assert reset during a 5-word burst.
  - Next cycle: out_valid = 0, dma_rdreq = 0, rptr = 0.
  - Late data_in arriving after reset is not enqueued.
